// File: rtl/if_id_fetch_ctrl.sv
// rtl/if_id_fetch_ctrl.sv - fetch PC and IF/ID register driven by hazard-unit stall/flush/pc_write
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   stall_i, flush_i, pc_write_i, branch_target_i : hazard unit controls
//   instr_i        : instruction memory data for address pc_o
//   pc_o           : current fetch address
//   if_id_pc_o, if_id_instr_o, if_id_valid_o : IF/ID pipeline register
//   hazard_err_o   : sticky protocol error (cleared by reset only)
//   stall_count_o, flush_count_o, bubble_count_o : only with IF_ID_FETCH_STATS_EN
//
// Optional feature macro: IF_ID_FETCH_STATS_EN (adds saturating event counters).
module if_id_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int          STALL_LIMIT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        pc_write_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
`ifdef IF_ID_FETCH_STATS_EN
  output logic [31:0] stall_count_o,
  output logic [31:0] flush_count_o,
  output logic [31:0] bubble_count_o,
`endif
  output logic        hazard_err_o
);

  localparam int CW = $clog2(STALL_LIMIT + 2);
  localparam logic [CW-1:0] CNT_LIM = CW'(STALL_LIMIT);
  localparam logic [CW-1:0] CNT_SAT = CW'(STALL_LIMIT + 1);

  typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;
  // HOLD: no stall/flush but pc_write_i=0, so the PC holds and IF/ID takes a bubble.
  typedef enum logic [1:0] {ACT_STALL, ACT_FLUSH, ACT_HOLD, ACT_ADV} act_t;

  state_t        state_q, state_d;
  act_t          act;
  logic [CW-1:0] stall_cnt_q;
  logic [31:0]   pc_d, ifid_pc_d, ifid_instr_d;
  logic          ifid_valid_d, err_set;

  // Action decode: stall beats flush beats advance. A flush with pc_write_i=0
  // still redirects, since the taken branch must not be lost.
  always_comb begin
    act = ACT_ADV;
    if (stall_i)          act = ACT_STALL;
    else if (flush_i)     act = ACT_FLUSH;
    else if (!pc_write_i) act = ACT_HOLD;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next-state logic: the state records the action taken this cycle.
  always_comb begin
    state_d = state_q;
    case (act)
      ACT_STALL: state_d = STALL;
      ACT_FLUSH: state_d = FLUSH;
      ACT_HOLD:  state_d = state_q;
      default:   state_d = RUN;
    endcase
  end

  // Output/datapath decode
  always_comb begin
    pc_d         = pc_o;
    ifid_pc_d    = if_id_pc_o;
    ifid_instr_d = if_id_instr_o;
    ifid_valid_d = if_id_valid_o;
    err_set      = 1'b0;
    case (act)
      ACT_STALL: begin
        // Protocol: a stall must hold the PC, and must not run too long.
        err_set = pc_write_i || (stall_cnt_q >= CNT_LIM);
      end
      ACT_FLUSH: begin
        pc_d         = branch_target_i;
        ifid_pc_d    = pc_o;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      ACT_HOLD: begin
        ifid_pc_d    = pc_o;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      default: begin
        pc_d         = pc_o + 32'd4;
        ifid_pc_d    = pc_o;
        ifid_instr_d = instr_i;
        ifid_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o          <= RESET_PC;
      if_id_pc_o    <= 32'd0;
      if_id_instr_o <= NOP_INSTR;
      if_id_valid_o <= 1'b0;
      hazard_err_o  <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      pc_o          <= pc_d;
      if_id_pc_o    <= ifid_pc_d;
      if_id_instr_o <= ifid_instr_d;
      if_id_valid_o <= ifid_valid_d;
      if (err_set) hazard_err_o <= 1'b1;
      if (act != ACT_STALL)         stall_cnt_q <= '0;
      else if (stall_cnt_q != CNT_SAT) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

`ifdef IF_ID_FETCH_STATS_EN
  logic bubble_ev;
  assign bubble_ev = (act == ACT_FLUSH || act == ACT_HOLD) && (state_q != BOOT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_count_o  <= 32'd0;
      flush_count_o  <= 32'd0;
      bubble_count_o <= 32'd0;
    end else begin
      if (act == ACT_STALL && stall_count_o != 32'hFFFF_FFFF)
        stall_count_o <= stall_count_o + 32'd1;
      if (act == ACT_FLUSH && flush_count_o != 32'hFFFF_FFFF)
        flush_count_o <= flush_count_o + 32'd1;
      if (bubble_ev && bubble_count_o != 32'hFFFF_FFFF)
        bubble_count_o <= bubble_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// tb/tb_if_id_fetch_ctrl.sv - self-checking bench for if_id_fetch_ctrl against a behavioural model
module tb_if_id_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int LIMIT = 2;

  logic clk = 1'b0;
  logic rst, stall, flush, pw;
  logic [31:0] tgt, instr, pc, ifpc, ifinstr;
  logic ifvalid, err;
  logic fixed_instr;
`ifdef IF_ID_FETCH_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] fetch(input logic [31:0] a, input logic fx);
    return fx ? 32'h00A0_0093 : (a ^ 32'h5A5A_1234) + 32'd7;
  endfunction

  assign instr = fetch(pc, fixed_instr);

  if_id_fetch_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .STALL_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .pc_write_i(pw),
    .branch_target_i(tgt), .instr_i(instr), .pc_o(pc), .if_id_pc_o(ifpc),
    .if_id_instr_o(ifinstr), .if_id_valid_o(ifvalid),
`ifdef IF_ID_FETCH_STATS_EN
    .stall_count_o(stall_cnt), .flush_count_o(flush_cnt), .bubble_count_o(bubble_cnt),
`endif
    .hazard_err_o(err)
  );

  // Reference model: fetch-side architectural state after each edge.
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  logic m_valid, m_err, m_boot;
  int m_run;
  longint m_stalls, m_flushes, m_bubbles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = NOP; m_valid = 1'b0;
      m_err = 1'b0; m_run = 0; m_boot = 1'b1;
      m_stalls = 0; m_flushes = 0; m_bubbles = 0;
    end else if (stall) begin
      if (pw) m_err = 1'b1;
      m_run++;
      if (m_run > LIMIT) m_err = 1'b1;
      m_stalls++;
      m_boot = 1'b0;
    end else begin
      m_run = 0;
      if (flush || !pw) begin
        if (!m_boot) m_bubbles++;
        m_ifpc = m_pc; m_ifinstr = NOP; m_valid = 1'b0;
        if (flush) begin
          m_pc = tgt; m_flushes++; m_boot = 1'b0;
        end
      end else begin
        m_ifpc = m_pc; m_ifinstr = fetch(m_pc, fixed_instr); m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_boot = 1'b0;
      end
    end
  endtask

  // Apply inputs (already driven), clock one edge, compare every output.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("if_id_pc", ifpc, m_ifpc);
    check("if_id_instr", ifinstr, m_ifinstr);
    check("if_id_valid", {31'd0, ifvalid}, {31'd0, m_valid});
    check("hazard_err", {31'd0, err}, {31'd0, m_err});
`ifdef IF_ID_FETCH_STATS_EN
    check("stall_count", stall_cnt, m_stalls[31:0]);
    check("flush_count", flush_cnt, m_flushes[31:0]);
    check("bubble_count", bubble_cnt, m_bubbles[31:0]);
`endif
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic w, input logic [31:0] t);
    rst = r; stall = s; flush = f; pw = w; tgt = t;
    step();
  endtask

  initial begin
    fixed_instr = 1'b1;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pw = 1'b1; tgt = 32'h0;
    #2;
    drive(1, 0, 0, 1, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", ifinstr, NOP);
    check("rst_valid", {31'd0, ifvalid}, 32'd0);

    // Plain advance
    drive(0, 0, 0, 1, 0);
    check("adv1_pc", pc, 32'd4);
    check("adv1_valid", {31'd0, ifvalid}, 32'd1);
    check("adv1_ifpc", ifpc, 32'd0);
    drive(0, 0, 0, 1, 0);
    check("adv2_pc", pc, 32'd8);

    // Single-cycle stall at pc 8
    drive(0, 1, 0, 0, 0);
    check("stall_pc", pc, 32'd8);
    check("stall_ifpc", ifpc, 32'd4);
    drive(0, 0, 0, 1, 0);
    check("resume_pc", pc, 32'd12);
    check("resume_err", {31'd0, err}, 32'd0);
    drive(0, 0, 0, 1, 0);
    check("adv_pc16", pc, 32'h10);

    // Flush at pc 0x10
    drive(0, 0, 1, 1, 32'h40);
    check("flush_pc", pc, 32'h40);
    check("flush_ifpc", ifpc, 32'h10);
    check("flush_instr", ifinstr, NOP);
    check("flush_valid", {31'd0, ifvalid}, 32'd0);
    drive(0, 0, 0, 1, 0);
    check("tgt_ifpc", ifpc, 32'h40);
    check("tgt_valid", {31'd0, ifvalid}, 32'd1);

    // Stall wins over flush, then the flush alone redirects
    drive(0, 1, 1, 0, 32'h80);
    check("stflush_pc", pc, 32'h44);
    drive(0, 0, 1, 1, 32'h80);
    check("flush2_pc", pc, 32'h80);

    // Three-cycle stall exceeds the limit
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("stall2_err", {31'd0, err}, 32'd0);
    drive(0, 1, 0, 0, 0);
    check("stall3_err", {31'd0, err}, 32'd1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 32'h100);
    check("err_sticky", {31'd0, err}, 32'd1);
    drive(1, 0, 0, 1, 0);
    check("err_cleared", {31'd0, err}, 32'd0);

    // Stall with pc_write asserted
    drive(0, 1, 0, 1, 0);
    check("pw_stall_err", {31'd0, err}, 32'd1);
    drive(1, 0, 0, 1, 0);

    // PC wrap, then reset mid-stall
    drive(0, 0, 1, 1, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1, 0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_ifpc", ifpc, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 1, 1, 32'h20);
    check("midstall_rst_pc", pc, 32'h0);
    check("midstall_rst_ifpc", ifpc, 32'h0);
    check("midstall_rst_valid", {31'd0, ifvalid}, 32'd0);

    // Randomized traffic
    fixed_instr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, s, f, w;
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 4) == 0);
      if (s) w = ($urandom_range(0, 7) == 0);
      else   w = ($urandom_range(0, 9) != 0);
      drive(r, s, f, w, {$urandom() & 32'hFFFF_FFFC});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
